universal_shift_register: RTL
=============================

// Module: universal_shift_register
// PURPOSE
//   Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with async reset,
//   true/inverted outputs and an op/handshake interface. Supports load, clear, invert and
//   multi-step shift/rotate bursts (one step per clock). Used as a datapath/serialiser element.
// PARAMETERS
//   WIDTH      8                  register width in bits (>=2)
//   CNT_W      4                  width of op_cnt; max burst length is 2**CNT_W-1
//   RESET_VAL  {WIDTH{1'b0}}      value loaded into the register on reset
// PORTS
//   clk_signal    in   1       clock, rising edge
//   rst_n_signal  in   1       asynchronous reset, active low
//   op_valid      in   1       operation request
//   op_code       in   3       0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROTL, 5 ROTR, 6 CLEAR, 7 INVERT
//   op_cnt        in   CNT_W   step count for codes 2..5 (ignored otherwise)
//   load_data     in   WIDTH   data for LOAD
//   ser_in        in   1       serial fill bit for SHL (into bit 0) / SHR (into bit WIDTH-1)
//   abort         in   1       terminate a running burst
//   op_ready      out  1       high when an op can be accepted (FSM in IDLE)
//   done          out  1       one-cycle pulse: accepted op completed
//   dout          out  WIDTH   register contents
//   dout_inv      out  WIDTH   ~dout (combinational)
//   ser_out       out  1       bit that left the register on the most recent shift/rotate step
// BEHAVIOUR
//   Reset (rst_n_signal=0, async): dout=RESET_VAL, dout_inv=~RESET_VAL, ser_out=0, done=0,
//     FSM=IDLE, op_ready=1, step counter=0. Reset mid-burst discards the burst; no done.
//   Accept: op_valid & op_ready sampled at rising edge k.
//   FSM states IDLE, RUN. op_ready = (state==IDLE).
//   Single-cycle ops (NOP, LOAD, CLEAR, INVERT): applied at edge k; done=1 in the cycle after
//     edge k; FSM stays IDLE (back-to-back ops accepted every cycle).
//   Shift/rotate, op_cnt=N:
//     N=0: register unchanged, ser_out unchanged, done after edge k, stay IDLE.
//     N=1: one step at edge k, done after edge k, stay IDLE.
//     N>1: step at edge k, go RUN, remaining=N-1; one step per edge while RUN; after the step
//       at edge k+N-1 go IDLE and done=1 in the following cycle. op_ready low for N-1 cycles.
//   Step: SHL dout<={dout[W-2:0],ser_in}, ser_out<=dout[W-1]; SHR dout<={ser_in,dout[W-1:1]},
//     ser_out<=dout[0]; ROTL/ROTR wrap the leaving bit into the vacated end, ser_out=leaving bit.
//   ser_in sampled anew at every step edge. op_code/op_cnt latched at accept; later changes ignored.
//   N>=WIDTH legal: rotate wraps (N=WIDTH restores value), shift fully refilled from ser_in.
//   abort: sampled only in RUN; takes priority over the step at that edge (no step), FSM->IDLE,
//     register keeps partially shifted value, no done. abort in IDLE ignored.
//   op_valid while op_ready=0: ignored, not queued.
//   Invalid WIDTH<2 or CNT_W<1: elaboration error.
// CONFIGURATION
//   USR_PARITY_EN defined: adds output parity_out (1 bit, combinational) = ^dout (even parity,
//     high when odd number of ones); reset value ^RESET_VAL.
//   USR_PARITY_EN undefined: parity_out port and logic absent; all other behaviour identical.
// TESTING  (WIDTH=8, CNT_W=4, RESET_VAL=0)
//   Reset then release -> dout=0x00, dout_inv=0xFF, op_ready=1, done=0, ser_out=0.
//   LOAD 0xA5; SHL cnt=3 ser_in=1 -> dout 0x4B,0x97,0x2F on successive edges, ser_out=1,
//     op_ready low 2 cycles, done single pulse after 3rd step.
//   LOAD 0x5A; ROTR cnt=8 -> dout=0x5A at end, done once; ROTL cnt=0 -> dout unchanged, done.
//   LOAD 0x81; ROTL cnt=5; abort at edge k+2 -> dout=0x06, no done, op_ready=1 next cycle.
//   LOAD 0x0F, INVERT back-to-back -> dout=0xF0, dout_inv=0x0F, two done pulses; CLEAR -> 0x00.
//   rst_n_signal low mid-burst (async, between edges) -> dout=0x00 immediately, op_ready=1, no
//     done; with USR_PARITY_EN: LOAD 0x07 -> parity_out=1, LOAD 0x03 -> parity_out=0.

Source files
------------

// File: rtl/universal_shift_register.sv
// Purpose : WIDTH-bit register with load/clear/invert and multi-step shift/rotate bursts, one step per clock.
// Latency : single-cycle ops and the first shift step apply at the accept edge; done pulses the cycle after the last step.
// Backpr. : op_ready drops while a burst is running; op_valid seen then is dropped, not queued. Optional USR_PARITY_EN adds parity_out.
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_signal,
  input  logic             rst_n_signal,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [CNT_W-1:0] op_cnt,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in,
  input  logic             abort,
  output logic             op_ready,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_inv,
  output logic             ser_out
`ifdef USR_PARITY_EN
  ,
  output logic             parity_out
`endif
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_SHL    = 3'd2;
  localparam logic [2:0] OP_SHR    = 3'd3;
  localparam logic [2:0] OP_ROTL   = 3'd4;
  localparam logic [2:0] OP_ROTR   = 3'd5;
  localparam logic [2:0] OP_CLEAR  = 3'd6;
  localparam logic [2:0] OP_INVERT = 3'd7;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Reject degenerate configurations at elaboration time.
  generate
    if (WIDTH < 2 || CNT_W < 1) begin : g_bad_param
      $error("universal_shift_register: WIDTH must be >= 2 and CNT_W >= 1");
    end
  endgenerate

  logic             r_state;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_remaining;
  logic [WIDTH-1:0] r_dout;
  logic             r_ser_out;
  logic             r_done;

  logic [2:0]       w_cur_op;
  logic [WIDTH-1:0] w_step_dout;
  logic             w_step_ser;

  // The op driving a step is the live op_code at accept, the latched one during a burst.
  assign w_cur_op = (r_state == ST_RUN) ? r_op : op_code;

  // Next register value and leaving bit for one shift/rotate step.
  always_comb begin
    w_step_dout = r_dout;
    w_step_ser  = r_ser_out;
    case (w_cur_op)
      OP_SHL: begin
        w_step_dout = {r_dout[WIDTH-2:0], ser_in};
        w_step_ser  = r_dout[WIDTH-1];
      end
      OP_SHR: begin
        w_step_dout = {ser_in, r_dout[WIDTH-1:1]};
        w_step_ser  = r_dout[0];
      end
      OP_ROTL: begin
        w_step_dout = {r_dout[WIDTH-2:0], r_dout[WIDTH-1]};
        w_step_ser  = r_dout[WIDTH-1];
      end
      OP_ROTR: begin
        w_step_dout = {r_dout[0], r_dout[WIDTH-1:1]};
        w_step_ser  = r_dout[0];
      end
      default: begin
        w_step_dout = r_dout;
        w_step_ser  = r_ser_out;
      end
    endcase
  end

  // Op acceptance, burst sequencing, abort handling and the done pulse.
  always_ff @(posedge clk_signal or negedge rst_n_signal) begin
    if (!rst_n_signal) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_remaining <= CNT_ZERO;
      r_dout      <= RESET_VAL;
      r_ser_out   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (op_valid) begin
          case (op_code)
            OP_NOP: begin
              r_done <= 1'b1;
            end
            OP_LOAD: begin
              r_dout <= load_data;
              r_done <= 1'b1;
            end
            OP_CLEAR: begin
              r_dout <= '0;
              r_done <= 1'b1;
            end
            OP_INVERT: begin
              r_dout <= ~r_dout;
              r_done <= 1'b1;
            end
            default: begin
              r_op <= op_code;
              // A zero-length burst leaves both the register and ser_out alone.
              if (op_cnt != CNT_ZERO) begin
                r_dout    <= w_step_dout;
                r_ser_out <= w_step_ser;
              end
              if (op_cnt > CNT_ONE) begin
                r_state     <= ST_RUN;
                r_remaining <= op_cnt - CNT_ONE;
              end else begin
                r_done <= 1'b1;
              end
            end
          endcase
        end
      end else begin
        if (abort) begin
          // Abort wins over the step: keep the partial value, no done.
          r_state     <= ST_IDLE;
          r_remaining <= CNT_ZERO;
        end else begin
          r_dout      <= w_step_dout;
          r_ser_out   <= w_step_ser;
          r_remaining <= r_remaining - CNT_ONE;
          if (r_remaining == CNT_ONE) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  assign op_ready = (r_state == ST_IDLE);
  assign done     = r_done;
  assign dout     = r_dout;
  assign dout_inv = ~r_dout;
  assign ser_out  = r_ser_out;

`ifdef USR_PARITY_EN
  assign parity_out = ^r_dout;
`endif

endmodule
